// File: rtl/blink_pkg.sv
// Shared mode encoding and sequencing for the LED blinker.
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_SLOW = 2'd1,
        MODE_FAST = 2'd2,
        MODE_ON   = 2'd3
    } mode_t;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_OFF:  return MODE_SLOW;
            MODE_SLOW: return MODE_FAST;
            MODE_FAST: return MODE_ON;
            default:   return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button front end: 2-flop synchroniser, run-length debounce, rising-edge press pulse.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic system1000,
    input  logic system1000_rstn,
    input  logic btn_raw,
    output logic press
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("btn_debounce: DEB_CYCLES must be >= 1");
    end

    logic [1:0]    sync_q;
    logic          db_q, db_d;
    logic          db_dly_q;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;

    // A level is accepted only on the DEB_CYCLES-th consecutive differing sample.
    always_comb begin
        deb_cnt_d = '0;
        db_d      = db_q;
        if (sync_q[1] != db_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                db_d = sync_q[1];
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            sync_q    <= '0;
            db_q      <= 1'b0;
            db_dly_q  <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync_q    <= {sync_q[0], btn_raw};
            db_q      <= db_d;
            db_dly_q  <= db_q;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign press = db_q & ~db_dly_q;

endmodule

// File: rtl/blink_mode_controller.sv
// Button-stepped mode FSM (OFF/SLOW/FAST/ON) driving a half-period LED blinker.
module blink_mode_controller
    import blink_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int DEB_CYCLES = 4,
    parameter int SLOW_HALF  = 500,
    parameter int FAST_HALF  = 125
) (
    input  logic       system1000,
    input  logic       system1000_rstn,
    input  logic       btn,
    input  logic       enable,
    output logic       led,
    output logic [1:0] mode,
    output logic       tick
);

    localparam logic [CNT_W-1:0] SLOW_RELOAD = CNT_W'(SLOW_HALF - 1);
    localparam logic [CNT_W-1:0] FAST_RELOAD = CNT_W'(FAST_HALF - 1);

    if (CNT_W < 1 || CNT_W > 62 ||
        SLOW_HALF < 1 || longint'(SLOW_HALF) > (longint'(1) << CNT_W) ||
        FAST_HALF < 1 || longint'(FAST_HALF) > (longint'(1) << CNT_W)) begin : g_bad_param
        $error("blink_mode_controller: half-periods must lie in 1..2^CNT_W");
    end

    logic             press;
    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             led_q, led_d;
    logic             tick_q, tick_d;
    logic             blinking;
    logic [CNT_W-1:0] reload;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .btn_raw         (btn),
        .press           (press)
    );

    // A press takes priority over counter expiry, so entry never ticks.
    always_comb begin
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        led_d    = led_q;
        tick_d   = 1'b0;
        blinking = (mode_q == MODE_SLOW) || (mode_q == MODE_FAST);
        reload   = (mode_q == MODE_SLOW) ? SLOW_RELOAD : FAST_RELOAD;
        if (press) begin
            mode_d = next_mode(mode_q);
            case (mode_d)
                MODE_SLOW: begin led_d = 1'b1; cnt_d = SLOW_RELOAD; end
                MODE_FAST: begin led_d = 1'b1; cnt_d = FAST_RELOAD; end
                MODE_ON:   begin led_d = 1'b1; cnt_d = '0;          end
                default:   begin led_d = 1'b0; cnt_d = '0;          end
            endcase
        end else if (blinking && enable) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                led_d  = ~led_q;
                cnt_d  = reload;
                tick_d = 1'b1;
            end
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            mode_q <= MODE_OFF;
            cnt_q  <= '0;
            led_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_blink_mode_controller.sv
// Scoreboard bench: behavioural model pushes expected outputs per edge, monitor compares on the falling edge.
module tb_blink_mode_controller;

    localparam int CNT_W = 16;
    localparam int DEB   = 4;
    localparam int SH    = 4;
    localparam int FH    = 3;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       btn  = 1'b0;
    logic       en   = 1'b1;
    logic       led;
    logic [1:0] mode;
    logic       tick;
    bit         clk_run = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    blink_mode_controller #(
        .CNT_W      (CNT_W),
        .DEB_CYCLES (DEB),
        .SLOW_HALF  (SH),
        .FAST_HALF  (FH)
    ) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .btn             (btn),
        .enable          (en),
        .led             (led),
        .mode            (mode),
        .tick            (tick)
    );

    function automatic void chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, expv, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit led;
        int mode;
        bit tick;
    } exp_t;

    exp_t exp_q[$];
    bit   hist[$];
    bit   s1, s2, lvl, lvl_prev;
    int   m_mode, m_e;
    bit   m_led, m_tick;
    bit   m_press, m_btn_s, m_flip;
    int   m_half;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 = 0; s2 = 0; lvl = 0; lvl_prev = 0;
            hist.delete();
            m_mode = 0; m_e = 0; m_led = 0; m_tick = 0;
            exp_q.delete();
        end else begin
            // button path: delayed twice, accepted after DEB unanimous differing samples
            m_btn_s  = s2;
            m_press  = lvl && !lvl_prev;
            lvl_prev = lvl;
            hist.push_back(m_btn_s);
            if (hist.size() > DEB) hist.delete(0);
            m_flip = (hist.size() == DEB);
            foreach (hist[i]) if (hist[i] == lvl) m_flip = 0;
            if (m_flip) lvl = m_btn_s;
            s2 = s1;
            s1 = btn;
            // blink: toggles on every HALF-th enabled cycle since mode entry
            m_tick = 0;
            if (m_press) begin
                m_mode = (m_mode + 1) % 4;
                m_e    = 0;
                m_led  = (m_mode != 0);
            end else if ((m_mode == 1 || m_mode == 2) && en) begin
                m_half = (m_mode == 1) ? SH : FH;
                m_e++;
                m_tick = (m_e % m_half) == 0;
                m_led  = ((m_e / m_half) % 2) == 0;
            end
            exp_q.push_back('{m_led, m_mode, m_tick});
        end
    end

    // ---------------- monitor ----------------
    exp_t ex;
    always @(negedge clk) begin
        if (!rstn) begin
            chk("rst_led", led, 0);
            chk("rst_mode", mode, 0);
            chk("rst_tick", tick, 0);
        end else if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            chk("led", led, ex.led);
            chk("mode", mode, ex.mode);
            chk("tick", tick, ex.tick);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn();
        btn = 1'b1;
        cyc(12);
        btn = 1'b0;
        cyc(12);
    endtask

    task automatic async_reset_check();
        @(negedge clk);
        clk_run = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_led", led, 0);
        chk("async_rst_mode", mode, 0);
        chk("async_rst_tick", tick, 0);
        #4;
        clk_run = 1'b1;
        cyc(3);
        rstn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        cyc(3);
        rstn = 1'b1;
        cyc(50);

        // short glitch must be discarded
        btn = 1'b1; cyc(DEB - 1);
        btn = 1'b0; cyc(20);

        // first press -> SLOW, observe blinking
        press_btn();
        cyc(40);

        // press timed to land exactly on a counter expiry
        cyc(10);
        guard = 0;
        while (((m_e + 7) % SH) != 0 && guard < 8) begin
            cyc(1);
            guard++;
        end
        btn = 1'b1; cyc(12);
        btn = 1'b0; cyc(12);

        // FAST with a pause
        cyc(1);
        en = 1'b0; cyc(10);
        en = 1'b1; cyc(20);

        // ON, OFF, SLOW (enable ignored in ON/OFF)
        press_btn();
        en = 1'b0; cyc(10); en = 1'b1; cyc(10);
        press_btn();
        cyc(20);
        en = 1'b0;
        press_btn();
        en = 1'b1;
        cyc(20);

        // randomised button bursts and enable
        for (int i = 0; i < 200; i++) begin
            btn = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 3) != 0);
            cyc($urandom_range(1, 12));
        end
        btn = 1'b0;
        en  = 1'b1;
        cyc(12);

        // reset mid-SLOW with the clock stopped, then first press lands in SLOW
        guard = 0;
        while (m_mode != 1 && guard < 6) begin
            press_btn();
            guard++;
        end
        cyc(5);
        async_reset_check();
        cyc(50);
        press_btn();
        cyc(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/blink_mode_controller.md
Name: blink_mode_controller

Overview:
Sequences the LED blinker datapath. A raw push-button is synchronised and debounced, and each clean press steps a 4-mode FSM: OFF, SLOW, FAST, ON. A half-period down-counter drives the LED toggle. Sits between the board button and LED pin, in place of a free-running blinker, in the system1000 clock domain.

Parameters:
CNT_W, 16, width of the half-period down-counter
DEB_CYCLES, 4, consecutive stable synchronised samples needed to accept a button level (>=1)
SLOW_HALF, 500, SLOW-mode half-period in clocks (1..2^CNT_W)
FAST_HALF, 125, FAST-mode half-period in clocks (1..2^CNT_W)

Ports:
system1000  input  1  clock, rising-edge
system1000_rstn  input  1  asynchronous active-low reset
btn  input  1  raw button, asynchronous, active-high
enable  input  1  1 = blink counter runs; 0 = freeze blink phase
led  output  1  LED drive, registered
mode  output  2  current mode: 0 OFF, 1 SLOW, 2 FAST, 3 ON, registered
tick  output  1  one-cycle pulse on every blink toggle, registered

Behaviour:
- Interface: one clock, system1000; reset system1000_rstn is asynchronous and active-low. All flops clear on reset assertion, with no clock required.
- Reset values: led=0, mode=OFF, tick=0, counter=0, sync flops=0, btn_db=0, btn_db_q=0, deb_cnt=0.
- Synchroniser: btn passes through a 2-flop chain to give btn_s.
- Debounce:
  - deb_cnt increments each cycle btn_s != btn_db and clears when they are equal.
  - When btn_s != btn_db and deb_cnt == DEB_CYCLES-1: btn_db <= btn_s and deb_cnt <= 0.
  - Any shorter pulse or glitch is discarded.
- Press event: press = btn_db & ~btn_db_q, with btn_db_q registered.
  - Latency: btn high sampled at edge k gives mode updated at edge k+DEB_CYCLES+2.
  - Release is never an event.
- Mode FSM, on press: OFF->SLOW->FAST->ON->OFF (wraps). No other transitions.
- Mode entry actions, on the same edge as the mode update:
  - Entering SLOW: led<=1, counter<=SLOW_HALF-1.
  - Entering FAST: led<=1, counter<=FAST_HALF-1.
  - Entering ON: led<=1, counter<=0.
  - Entering OFF: led<=0, counter<=0.
  - tick stays 0 on a mode change.
- SLOW/FAST steady state, enable=1:
  - counter!=0: counter decrements.
  - counter==0: led toggles, counter reloads with HALF-1, tick<=1 for exactly one cycle.
  - LED period = 2*HALF clocks.
  - HALF=1 toggles every cycle, with tick held high continuously.
- SLOW/FAST with enable=0: counter and led hold, tick=0. Resumes from the held value with no reload.
- OFF/ON: led constant (0/1), tick=0, counter held at 0. enable is ignored.
- Simultaneous press and counter expiry: press wins. Entry action applies, no tick.
- Press while enable=0: still accepted. Entry action applies.
- Reset mid-blink: immediate return to reset values. After release, the first press lands in SLOW.
- Widths: counter is CNT_W bits unsigned. HALF-1 is truncated to CNT_W; parameter legality is checked by elaboration assertion.

Decomposition:
- Package blink_pkg:
  - mode encodings MODE_OFF=2'd0, MODE_SLOW=2'd1, MODE_FAST=2'd2, MODE_ON=2'd3;
  - mode_t 2-bit typedef;
  - next-mode function.
- Sub-module btn_debounce (synchroniser + debounce + rising-edge pulse).
  - Parameter: DEB_CYCLES.
  - Ports: system1000, system1000_rstn, btn_raw, press.
  - Is reused by other board-input blocks.
- Top holds the mode FSM, counter, led and tick.

Test Plan:
- Reset: assert rstn=0 mid-cycle with clock stopped -> led=0, mode=0, tick=0 immediately. Release, idle 50 clocks -> outputs unchanged.
- Glitch: btn high for DEB_CYCLES-1=3 clocks then low -> mode stays 0. btn high 20 clocks -> mode=1 exactly 6 edges after first high sample, led=1.
- SLOW blink with SLOW_HALF=4 for sim, enable=1 -> led toggles every 4 clocks, tick pulses 1 cycle per toggle, period 8.
- Wrap: 4 clean presses -> mode 1,2,3,0. led=1 in ON, led=0 in OFF, no tick in ON/OFF.
- Pause: in FAST with FAST_HALF=3, drop enable after 1 count for 10 clocks -> led/counter frozen, tick=0. Raise enable -> toggle after remaining 2 clocks.
- Collision and reset: press landing on counter expiry -> mode advances, no tick. Reset during SLOW -> led=0, mode=0. Next press -> SLOW.
